// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared calculator definitions: operand/result widths, the conversion
// iteration count, the sequencer state enum (also consumed by the
// calculator FSM) and a BCD digit validity helper.
// No ports.
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int BCD_W       = 16;               // 4 packed BCD digits
    localparam int BIN_W       = 14;               // 0..9999 fits in 14 bits
    localparam int DIGITS      = 4;
    localparam int CONV_CYCLES = 14;               // one shift per result bit
    localparam int WORK_W      = BCD_W + BIN_W;    // {bcd, binary} work register
    localparam int CNT_W       = 4;                // holds 0..CONV_CYCLES-1

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when any nibble of a packed BCD word is outside 0..9.
    function automatic logic bcd_has_invalid(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Reverse double-dabble correction for one BCD digit, applied after the
// right shift: a digit of 8 or more received a carried-in half-weight bit
// (worth 8 in the nibble but only 5 in decimal), so 3 is removed.
// Ports:
//   din   in  4  digit value after the shift
//   dout  out 4  corrected digit
// ---------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq
// Sequential 4-digit BCD to 14-bit binary converter using iterative reverse
// double-dabble: the 30-bit work register {bcd, 14'b0} is shifted right once
// per cycle and every BCD digit corrected, for 14 cycles; the low 14 bits
// then hold the binary value.
//
// Optional feature (macro BCD2BIN_DIGIT_CHECK_EN): an operand with any digit
// above 9 skips the iterations, completing one cycle after acceptance with
// bin_out = 0 and err = 1. Without the macro err is constant 0.
//
// Ports:
//   clock      in  1   system clock, rising edge
//   btn_reset  in  1   asynchronous active-low reset
//   start      in  1   conversion request, accepted in IDLE or DONE
//   bcd_in     in  16  packed BCD operand, [15:12] most significant
//   busy       out 1   conversion in progress
//   done       out 1   one-cycle pulse, bin_out/err freshly updated
//   bin_out    out 14  binary result, held until the next completion
//   err        out 1   invalid digit on the last accepted operand
// ---------------------------------------------------------------------------
module bcd2bin_seq
    import calc_pkg::*;
(
    input  logic             clock,
    input  logic             btn_reset,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd_in,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] bin_out,
    output logic             err
);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   work_shr;
    logic [WORK_W-1:0]   work_adj;
    logic [BIN_W-1:0]    bin_r;
    logic                accept;
    logic                last_iter;
    logic                entering_done;

    // ------------------------------------------------------------------
    // One iteration: shift the whole register, then correct each digit.
    // ------------------------------------------------------------------
    assign work_shr = work >> 1;
    assign work_adj[BIN_W-1:0] = work_shr[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .din  (work_shr[BIN_W + 4*g +: 4]),
            .dout (work_adj[BIN_W + 4*g +: 4])
        );
    end

    assign accept        = start && ((state == IDLE) || (state == DONE));
    assign last_iter     = (cnt == CNT_W'(CONV_CYCLES - 1));
    assign entering_done = (state == SHIFT) && (state_nxt == DONE);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic bad_q;    // accepted operand had a non-decimal digit
    logic err_r;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge btn_reset) begin
        if (!btn_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_nxt is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
                if (bad_q || last_iter) state_nxt = DONE;
`else
                if (last_iter) state_nxt = DONE;
`endif
            end
            DONE: begin
                state_nxt = start ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: work register, iteration counter, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge btn_reset) begin
        if (!btn_reset) begin
            work  <= '0;
            cnt   <= '0;
            bin_r <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_q <= 1'b0;
            err_r <= 1'b0;
`endif
        end else if (accept) begin
            work  <= {bcd_in, {BIN_W{1'b0}}};
            cnt   <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            bad_q <= bcd_has_invalid(bcd_in);
`endif
        end else if (state == SHIFT) begin
            work <= work_adj;
            cnt  <= cnt + CNT_W'(1);
            if (entering_done) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
                bin_r <= bad_q ? '0 : work_adj[BIN_W-1:0];
                err_r <= bad_q;
`else
                bin_r <= work_adj[BIN_W-1:0];
`endif
            end
        end
    end

    // Outputs decode registered state only; no input-to-output path.
    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);
    assign bin_out = bin_r;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign err     = err_r;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd2bin_seq
// Self-checking bench for bcd2bin_seq. A decimal-arithmetic model predicts
// busy/done/bin_out/err every cycle; directed tasks add literal expectations
// for latency, results, ignored starts, back-to-back and mid-run reset.
// Build with BCD2BIN_DIGIT_CHECK_EN defined to also exercise the digit check.
// ---------------------------------------------------------------------------
module tb_bcd2bin_seq;

    logic        clock = 1'b0;
    logic        btn_reset;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] bin_out;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd2bin_seq dut (
        .clock     (clock),
        .btn_reset (btn_reset),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: decimal value of the digits, fixed latency.
    // ------------------------------------------------------------------
    function automatic int bcd_value(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic has_bad(input logic [15:0] v);
        return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    int          m_left;        // cycles until completion, 0 when not busy
    logic        m_done;
    logic [13:0] m_bin;
    logic        m_err;
    logic        m_known;       // m_bin is a defined result
    logic [13:0] m_pend_bin;
    logic        m_pend_err;
    logic        m_pend_known;

    always @(posedge clock or negedge btn_reset) begin
        if (!btn_reset) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_bin   <= '0;
            m_err   <= 1'b0;
            m_known <= 1'b1;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done  <= 1'b1;
                m_bin   <= m_pend_bin;
                m_err   <= m_pend_err;
                m_known <= m_pend_known;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
                if (has_bad(bcd_in)) begin
                    m_left       <= 1;
                    m_pend_bin   <= '0;
                    m_pend_err   <= 1'b1;
                    m_pend_known <= 1'b1;
                end else begin
                    m_left       <= 14;
                    m_pend_bin   <= 14'(bcd_value(bcd_in));
                    m_pend_err   <= 1'b0;
                    m_pend_known <= 1'b1;
                end
`else
                m_left       <= 14;
                m_pend_bin   <= 14'(bcd_value(bcd_in));
                m_pend_err   <= 1'b0;
                m_pend_known <= !has_bad(bcd_in);
`endif
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clock) begin
        check("model_busy", busy, m_left > 0);
        check("model_done", done, m_done);
        check("model_err", err, m_err);
        check("busy_done_excl", busy & done, 1'b0);
        if (m_known) check("model_bin", bin_out, m_bin);
    end

    // ------------------------------------------------------------------
    // Directed tasks (each starts and ends just after a falling edge)
    // ------------------------------------------------------------------
    task automatic convert(input string name, input logic [15:0] v, input logic [13:0] exp_bin,
                           input logic exp_err, input int exp_lat);
        int cyc;
        bcd_in = v;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_bin"}, bin_out, exp_bin);
        check({name, "_err"}, err, exp_err);
        @(negedge clock);
        check({name, "_done_drop"}, done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int first;
        int cyc;

        // Reset held with start asserted: nothing may start.
        btn_reset = 1'b0;
        start     = 1'b1;
        bcd_in    = 16'h9999;
        repeat (4) @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bin", bin_out, 14'd0);
        check("rst_err", err, 1'b0);
        start = 1'b0;
        btn_reset = 1'b1;
        @(negedge clock);

        // Max and zero.
        convert("max", 16'h9999, 14'h270F, 1'b0, 14);
        convert("zero", 16'h0000, 14'h0000, 1'b0, 14);

        // Mixed value with a start pulse during busy that must be ignored.
        bcd_in = 16'h1234;
        start  = 1'b1;
        @(negedge clock);
        pulses = 0;
        first  = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                bcd_in = 16'h0042;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (done) begin
                pulses++;
                if (first == 0) first = c;
                check("mixed_bin", bin_out, 14'h04D2);
            end
        end
        check("ignored_pulses", pulses, 1);
        check("ignored_latency", first, 14);

        // Back-to-back: second start during the done cycle.
        bcd_in = 16'h0007;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        check("b2b_first_lat", cyc, 14);
        check("b2b_first_bin", bin_out, 14'd7);
        bcd_in = 16'h0100;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("b2b_busy_again", busy, 1'b1);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        check("b2b_gap", cyc, 15);
        check("b2b_second_bin", bin_out, 14'd100);
        @(negedge clock);

        // Reset in the middle of a conversion.
        bcd_in = 16'h5678;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        check("midrst_busy_before", busy, 1'b1);
        #2 btn_reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_bin", bin_out, 14'd0);
        check("midrst_err", err, 1'b0);
        @(negedge clock);
        btn_reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("midrst_no_done", pulses, 0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
        convert("bad_digit", 16'h12A4, 14'd0, 1'b1, 1);
        convert("after_bad", 16'h0010, 14'd10, 1'b0, 14);
`else
        convert("after_rst", 16'h0010, 14'd10, 1'b0, 14);
`endif
        convert("mid_value", 16'h4096, 14'd4096, 1'b0, 14);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd2bin_seq.md
# bcd2bin_seq

Sequential BCD-to-binary converter: the inverse of the calculator's binary-to-BCD path. It takes a 4-digit packed BCD operand, for example one entered digit-by-digit on a keypad front end, and produces the 14-bit binary value the ALU consumes. It uses iterative reverse double-dabble (shift right, then correct each digit) over 14 clock cycles, with a start/busy/done handshake. It sits between operand entry logic and the calculator FSM's operand registers.

## Interface
Parameters:
- none; widths come from the shared package.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge
- btn_reset  in  1  asynchronous, active-low reset
- start  in  1  request a conversion; sampled on a rising edge
- bcd_in  in  16  packed BCD, 4 digits, [15:12] most significant
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse: bin_out/err are valid and freshly updated
- bin_out  out  14  binary result, range 0..9999; held until the next completion
- err  out  1  an invalid digit was detected on the last accepted operand; held with bin_out

## Operation
- States: IDLE, SHIFT, DONE.
- **Start acceptance:** start is accepted only in IDLE or DONE. Acceptance loads a 30-bit work register {bcd_in, 14'b0}, clears the iteration counter and enters SHIFT. start in SHIFT is ignored; it is not queued.
- **Each SHIFT cycle:**
  - Logical shift right by 1 of the whole 30-bit register.
  - Then, for each of the 4 BCD nibbles, if the nibble is >= 8, subtract 3.
  - Counter increments.
- **Leaving SHIFT:** after the 14th iteration, the low 14 bits are registered into bin_out, err is cleared, and the FSM enters DONE.
- **DONE:**
  - Lasts one cycle; done = 1.
  - Goes to SHIFT if start is high, else to IDLE.
- bin_out and err change only on the edge that enters DONE.
- **Arithmetic:** all correction is nibble-local 4-bit unsigned. For valid BCD, a nibble never underflows after the shift. The maximum result is 9999 = 14'h270F, so no overflow is possible.
- **Reset (async, btn_reset low):**
  - state = IDLE, counter = 0.
  - busy = 0, done = 0, bin_out = 0, err = 0.
  - Reset mid-conversion abandons the operation; no done pulse is produced.

## Timing
- Start accepted on edge E0; busy = 1 from E0 until E14.
- Iterations occur on edges E1..E14.
- done = 1 and bin_out/err are valid from E14 to E15; done drops on E15.
- Latency: 14 cycles start-to-done for valid operands.
- Back-to-back: start high during the DONE cycle is accepted at E15. Throughput is one conversion per 15 cycles.
- busy = 0 in IDLE and DONE; done and busy are never high together.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- **Defined:**
  - On acceptance, any bcd_in nibble > 9 bypasses SHIFT: the FSM goes to DONE on the next edge (latency 1).
  - That edge sets bin_out = 0 and err = 1.
  - busy is high for that single cycle.
- **Undefined:**
  - No check is performed and err is tied to 0.
  - Invalid digits go through the normal 14-cycle algorithm; the result is deterministic but unspecified.

## Structure
- Shared package calc_pkg holds:
  - BCD_W = 16, BIN_W = 14, DIGITS = 4, CONV_CYCLES = 14.
  - The state enum (IDLE, SHIFT, DONE), which the calculator FSM also consumes.
- Sub-module bcd_digit_adj: 4-bit combinational correction (if in >= 8 then out = in - 3, else out = in). It is instantiated once per digit, after the shift.
- The top module holds the FSM, counter, work register and output registers.

## Test plan
- **Reset:** btn_reset low, with clock running and start = 1 -> busy = 0, done = 0, bin_out = 0, err = 0; no conversion starts until reset is released.
- **Max and zero values:** bcd_in = 16'h9999, start for 1 cycle -> done pulse exactly 14 cycles later, bin_out = 14'h270F, err = 0. Then bcd_in = 16'h0000 -> bin_out = 0.
- **Mixed value and ignored start:** bcd_in = 16'h1234 -> bin_out = 14'h04D2. A second start with bcd_in = 16'h0042 pulsed at cycle 5 of busy is ignored; the result is still 14'h04D2 and there is only one done pulse.
- **Back-to-back:** bcd_in = 16'h0007, then 16'h0100 with start high during the done cycle -> two done pulses 15 cycles apart, bin_out 7 then 100.
- **Reset mid-conversion:** assert btn_reset at cycle 7 of a 16'h5678 conversion -> outputs return to reset values immediately, and no done pulse follows release.
- **Digit check (BCD2BIN_DIGIT_CHECK_EN defined):** bcd_in = 16'h12A4 -> done after 1 cycle, err = 1, bin_out = 0. A following valid 16'h0010 -> err = 0, bin_out = 10.
